data_mem_be: RTL and testbench
==============================

DATA_MEM_BE -- requirements
Module: data_mem_be

Interface
REQ-001 Parameter A_WIDTH, default 8: word-address width; depth DEPTH = 2**A_WIDTH words.
REQ-002 Parameter D_WIDTH, default 32: word width; SHALL be a multiple of 8; NB = D_WIDTH/8 byte lanes.
REQ-003 Parameter CLEAR_ON_RESET, default 1: 1 = zero all words after reset; 0 = skip clear.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 we  in  1  write request.
REQ-007 w_addr  in  A_WIDTH  write word address.
REQ-008 w_be  in  NB  write byte-enable mask, bit i gates bits [8i+7:8i].
REQ-009 w_data  in  D_WIDTH  write data.
REQ-010 re  in  1  read request.
REQ-011 r_addr  in  A_WIDTH  read word address.
REQ-012 r_data  out  D_WIDTH  registered read data.
REQ-013 r_valid  out  1  high for the cycle r_data was updated by an accepted read.
REQ-014 ready  out  1  high when requests are accepted.
REQ-015 err  out  1  one-cycle pulse: request presented while ready low.

Function
REQ-016 Two-state FSM: CLEAR, RUN; ready = (state == RUN), registered.
REQ-017 CLEAR: each cycle write all-zero to mem[clr_cnt], clr_cnt += 1; after writing DEPTH-1 go to RUN next edge; clear takes exactly DEPTH cycles.
REQ-018 RUN: write accepted when we=1 -- only lanes with w_be[i]=1 updated; w_be=0 leaves word unchanged.
REQ-019 RUN: read accepted when re=1 -- r_data valid one cycle later, r_valid=1 that cycle.
REQ-020 Write-through per byte: same-cycle we, re, w_addr==r_addr -> lane i of r_data = w_data lane i if w_be[i], else old mem lane i.
REQ-021 re=0 or not ready: r_data holds previous value, r_valid=0.
REQ-022 we or re while ready=0: request ignored (no mem write, r_data unchanged), err=1 next cycle; otherwise err=0.
REQ-023 Simultaneous write/read to different addresses: both complete independently in the same cycle.
REQ-024 clr_cnt is A_WIDTH bits; terminal compare on DEPTH-1, no wrap beyond.

Reset
REQ-025 On rst: r_data=0, r_valid=0, err=0, ready=0, clr_cnt=0, state=CLEAR if CLEAR_ON_RESET=1 else RUN (ready=1 first edge after release).
REQ-026 rst during CLEAR restarts the clear from address 0; rst during RUN does not alter mem contents except via subsequent clear.
REQ-027 Memory array itself has no reset; zeroing occurs only via the CLEAR sequence.

Structure
REQ-028 Package data_mem_pkg holds the state type (CLEAR, RUN) and the NB lane-count function.
REQ-029 One sub-module data_mem_byte_merge: combinational per-lane mux of new/old word by byte mask, used by both the write path and the bypass path.
REQ-030 Memory array inferable as block RAM with byte-write enables; no other sub-modules.

Verification
REQ-031 Reset release, CLEAR_ON_RESET=1, A_WIDTH=4 -> ready low 16 cycles, rises cycle 16; reads of all 16 addresses return 0x00000000.
REQ-032 Write addr 3 = 0xAABBCCDD be=1111, then be=0101 data 0x11223344 -> read addr 3 returns 0xAA22CC44 one cycle after re.
REQ-033 Same cycle we addr 5 data 0x12345678 be=0011, re addr 5, old value 0xFFFFFFFF -> r_data=0xFFFF5678 next cycle, r_valid=1.
REQ-034 re=1 and we=1 during CLEAR -> err=1 next cycle, r_data unchanged, r_valid=0, target word still 0 after clear.
REQ-035 rst asserted at clear count 7 -> clr_cnt=0, ready=0, r_data=0 immediately; ready rises DEPTH cycles after release.
REQ-036 CLEAR_ON_RESET=0 -> ready=1 first edge after reset release; write/read addr 0 0xDEADBEEF round-trips with 1-cycle latency.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the byte-enabled data memory.
package data_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  function automatic int nb_lanes(input int d_width);
    return d_width / 8;
  endfunction

endpackage

// File: rtl/data_mem_byte_merge.sv
// Per-lane select between a new and an old word under a byte mask.
module data_mem_byte_merge #(
  parameter int D_WIDTH = 32,
  parameter int NB      = D_WIDTH / 8
) (
  input  logic [D_WIDTH-1:0] new_i,
  input  logic [D_WIDTH-1:0] old_i,
  input  logic [NB-1:0]      be_i,
  output logic [D_WIDTH-1:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int i = 0; i < NB; i++) begin
      if (be_i[i]) merged_o[8*i +: 8] = new_i[8*i +: 8];
    end
  end

endmodule

// File: rtl/data_mem_be.sv
// Byte-enabled single-clock data memory with a post-reset zeroing sweep
// and same-cycle per-byte write-through on the read port.
module data_mem_be
  import data_mem_pkg::*;
#(
  parameter int A_WIDTH        = 8,
  parameter int D_WIDTH        = 32,
  parameter int CLEAR_ON_RESET = 1,
  localparam int NB            = nb_lanes(D_WIDTH),
  localparam int DEPTH         = 2 ** A_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [A_WIDTH-1:0] w_addr,
  input  logic [NB-1:0]      w_be,
  input  logic [D_WIDTH-1:0] w_data,
  input  logic               re,
  input  logic [A_WIDTH-1:0] r_addr,
  output logic [D_WIDTH-1:0] r_data,
  output logic               r_valid,
  output logic               ready,
  output logic               err,
  output state_t             dbg_state_o
);

  // Handshake: a request (we or re) is accepted in any cycle where ready is
  // high; there is no back-pressure beyond that. A request seen while ready
  // is low is dropped and flagged by a one-cycle err pulse on the next cycle.

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

  state_t             state_q, state_d;
  logic [A_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic               ready_q;
  logic [D_WIDTH-1:0] r_data_q;
  logic               r_valid_q;
  logic               err_q;

  logic [D_WIDTH-1:0] mem [DEPTH];

  logic               clearing;
  logic               wr_en;
  logic [A_WIDTH-1:0] wr_addr;
  logic [D_WIDTH-1:0] wr_new;
  logic [NB-1:0]      wr_be;
  logic [D_WIDTH-1:0] wr_word;
  logic [NB-1:0]      byp_be;
  logic [D_WIDTH-1:0] rd_word;
  logic               rd_acc;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        if (clr_cnt_q == A_WIDTH'(DEPTH - 1)) state_d = RUN;
        else clr_cnt_d = clr_cnt_q + 1'b1;
      end
      RUN: begin
        state_d = RUN;
      end
      default: state_d = RESET_STATE;
    endcase
  end

  // The clear sweep reuses the write merge with a full mask and zero data.
  always_comb begin
    clearing = (state_q == CLEAR);
    wr_en    = !rst && (clearing || (ready_q && we));
    wr_addr  = clearing ? clr_cnt_q : w_addr;
    wr_new   = clearing ? '0 : w_data;
    wr_be    = clearing ? '1 : w_be;
    rd_acc   = ready_q && re;
    byp_be   = (we && (w_addr == r_addr)) ? w_be : '0;
  end

  data_mem_byte_merge #(.D_WIDTH(D_WIDTH), .NB(NB)) u_wr_merge (
    .new_i    (wr_new),
    .old_i    (mem[wr_addr]),
    .be_i     (wr_be),
    .merged_o (wr_word)
  );

  data_mem_byte_merge #(.D_WIDTH(D_WIDTH), .NB(NB)) u_rd_merge (
    .new_i    (w_data),
    .old_i    (mem[r_addr]),
    .be_i     (byp_be),
    .merged_o (rd_word)
  );

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RESET_STATE;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= (state_d == RUN);
      err_q     <= (we || re) && !ready_q;
      r_valid_q <= rd_acc;
      if (rd_acc) r_data_q <= rd_word;
    end
  end

  assign r_data      = r_data_q;
  assign r_valid     = r_valid_q;
  assign ready       = ready_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_data_mem_be.sv
// Randomized check of data_mem_be against a behavioural memory model.
module tb_data_mem_be;
  import data_mem_pkg::*;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  // Instance with clear-on-reset
  logic          rst    = 1'b1;
  logic          we     = 1'b0;
  logic [AW-1:0] w_addr = '0;
  logic [3:0]    w_be   = '0;
  logic [DW-1:0] w_data = '0;
  logic          re     = 1'b0;
  logic [AW-1:0] r_addr = '0;
  logic [DW-1:0] r_data;
  logic          r_valid, ready, err;
  state_t        dbg_state;

  // Instance without clear-on-reset
  logic          n_rst    = 1'b1;
  logic          n_we     = 1'b0;
  logic [AW-1:0] n_w_addr = '0;
  logic [3:0]    n_w_be   = '0;
  logic [DW-1:0] n_w_data = '0;
  logic          n_re     = 1'b0;
  logic [AW-1:0] n_r_addr = '0;
  logic [DW-1:0] n_r_data;
  logic          n_r_valid, n_ready, n_err;
  state_t        n_dbg_state;

  data_mem_be #(.A_WIDTH(AW), .D_WIDTH(DW), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst(rst), .we(we), .w_addr(w_addr), .w_be(w_be), .w_data(w_data),
    .re(re), .r_addr(r_addr), .r_data(r_data), .r_valid(r_valid), .ready(ready),
    .err(err), .dbg_state_o(dbg_state)
  );

  data_mem_be #(.A_WIDTH(AW), .D_WIDTH(DW), .CLEAR_ON_RESET(0)) dut_nc (
    .clk(clk), .rst(n_rst), .we(n_we), .w_addr(n_w_addr), .w_be(n_w_be), .w_data(n_w_data),
    .re(n_re), .r_addr(n_r_addr), .r_data(n_r_data), .r_valid(n_r_valid), .ready(n_ready),
    .err(n_err), .dbg_state_o(n_dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: contents, held read data, cycles until ready
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_rdata;
  int            m_wait;
  logic [DW-1:0] exp_q [$];

  // Asserts reset mid-cycle; a full clear always precedes any accepted
  // access, so the model memory is simply all zeros afterwards.
  task automatic do_reset();
    rst = 1'b1;
    we = 1'b0; re = 1'b0;
    #1;
    check("rst_r_data", r_data, 32'h0);
    check("rst_r_valid", r_valid, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_ready", ready, 1'b0);
    check("rst_state", dbg_state, CLEAR);
    m_rdata = '0;
    exp_q.delete();
    m_wait = DEPTH;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic cycle(input logic i_we, input logic [AW-1:0] i_wa, input logic [3:0] i_be,
                       input logic [DW-1:0] i_wd, input logic i_re, input logic [AW-1:0] i_ra);
    bit acc;
    bit exp_err;
    we = i_we; w_addr = i_wa; w_be = i_be; w_data = i_wd;
    re = i_re; r_addr = i_ra;
    acc     = (m_wait == 0);
    exp_err = (i_we || i_re) && !acc;
    // Write-through means a read sees the word as it is after this cycle's write.
    if (acc && i_we) begin
      for (int b = 0; b < 4; b++)
        if (i_be[b]) m_mem[i_wa][8*b +: 8] = i_wd[8*b +: 8];
    end
    if (acc && i_re) exp_q.push_back(m_mem[i_ra]);
    if (m_wait > 0) m_wait--;
    @(posedge clk); #1;
    check("ready", ready, m_wait == 0);
    check("err", err, exp_err);
    check("r_valid", r_valid, acc && i_re);
    if (exp_q.size() > 0) m_rdata = exp_q.pop_front();
    check("r_data", r_data, m_rdata);
    we = 1'b0; re = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic random_phase(input int n);
    logic [AW-1:0] wa, ra;
    for (int k = 0; k < n; k++) begin
      wa = AW'($urandom_range(0, DEPTH - 1));
      ra = ($urandom_range(0, 1) == 1) ? wa : AW'($urandom_range(0, DEPTH - 1));
      cycle(1'($urandom_range(0, 1)), wa, 4'($urandom_range(0, 15)), $urandom,
            1'($urandom_range(0, 1)), ra);
    end
  endtask

  initial begin
    @(posedge clk); #1;

    // Requests during clear are dropped and flagged
    do_reset();
    cycle(1'b1, 4'd9, 4'hF, 32'hCAFEF00D, 1'b1, 4'd9);
    check("clear_state", dbg_state, CLEAR);
    for (int i = 0; i < DEPTH - 1; i++) idle();
    check("run_state", dbg_state, RUN);

    // Every word reads back zero after the clear
    for (int a = 0; a < DEPTH; a++) cycle(1'b0, '0, '0, '0, 1'b1, AW'(a));
    check("clear_addr9", r_data, 32'h0);
    idle();

    // Partial byte overwrite
    cycle(1'b1, 4'd3, 4'hF, 32'hAABBCCDD, 1'b0, '0);
    cycle(1'b1, 4'd3, 4'h5, 32'h11223344, 1'b0, '0);
    cycle(1'b0, '0, '0, '0, 1'b1, 4'd3);
    check("be_merge", r_data, 32'hAA22CC44);

    // Same-address write-through per byte
    cycle(1'b1, 4'd5, 4'hF, 32'hFFFFFFFF, 1'b0, '0);
    cycle(1'b1, 4'd5, 4'h3, 32'h12345678, 1'b1, 4'd5);
    check("bypass", r_data, 32'hFFFF5678);
    check("bypass_valid", r_valid, 1'b1);

    // Write and read to different addresses in one cycle
    cycle(1'b1, 4'd7, 4'hF, 32'h0BADF00D, 1'b1, 4'd5);
    check("diff_addr_read", r_data, 32'hFFFF5678);
    cycle(1'b0, '0, '0, '0, 1'b1, 4'd7);
    check("diff_addr_write", r_data, 32'h0BADF00D);
    idle();
    check("hold_r_data", r_data, 32'h0BADF00D);

    random_phase(400);

    // Reset from RUN, then reset again at clear count 7
    do_reset();
    for (int i = 0; i < 7; i++) idle();
    do_reset();
    for (int i = 0; i < DEPTH; i++) idle();
    check("reclear_ready", ready, 1'b1);
    random_phase(200);

    // No-clear variant: ready on the first edge, one-cycle read latency
    n_rst = 1'b1;
    #1;
    check("nc_rst_ready", n_ready, 1'b0);
    check("nc_rst_state", n_dbg_state, RUN);
    @(posedge clk); #1;
    n_rst = 1'b0;
    @(posedge clk); #1;
    check("nc_ready", n_ready, 1'b1);
    n_we = 1'b1; n_w_addr = '0; n_w_be = 4'hF; n_w_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    check("nc_no_err", n_err, 1'b0);
    n_we = 1'b0; n_re = 1'b1; n_r_addr = '0;
    @(posedge clk); #1;
    check("nc_r_valid", n_r_valid, 1'b1);
    check("nc_r_data", n_r_data, 32'hDEADBEEF);
    n_re = 1'b0;
    @(posedge clk); #1;
    check("nc_valid_drop", n_r_valid, 1'b0);
    check("nc_hold", n_r_data, 32'hDEADBEEF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
